// File: rtl/pipe_pkg.sv
// pipe_pkg: shared forwarding selects, hazard FSM states and register constants
package pipe_pkg;
   localparam logic [1:0] FWD_RF    = 2'b00;
   localparam logic [1:0] FWD_MEMWB = 2'b01;
   localparam logic [1:0] FWD_EXMEM = 2'b10;
   localparam int         REG_X0    = 0;
   typedef enum logic {ST_IDLE = 1'b0, ST_STALL = 1'b1} state_t;
endpackage

// File: rtl/hazard_forwarding_ctrl_fwd_select.sv
// fwd_select: single-operand bypass priority comparator (EX/MEM over MEM/WB over regfile)
module fwd_select
   import pipe_pkg::*;
#(
   parameter int REG_AW = 5
) (
   input  logic [REG_AW-1:0] rs,
   input  logic              used,
   input  logic [REG_AW-1:0] exmem_rd,
   input  logic              exmem_wb,
   input  logic [REG_AW-1:0] memwb_rd,
   input  logic              memwb_wb,
   output logic [1:0]        sel
);
   logic ex_hit;
   logic mem_hit;
   // x0 is hardwired zero, so a write to it must never be bypassed
   always_comb begin
      ex_hit  = exmem_wb && used && (exmem_rd != REG_AW'(REG_X0)) && (exmem_rd == rs);
      mem_hit = memwb_wb && used && (memwb_rd != REG_AW'(REG_X0)) && (memwb_rd == rs);
      sel     = ex_hit ? FWD_EXMEM : mem_hit ? FWD_MEMWB : FWD_RF;
   end
endmodule

// File: rtl/hazard_forwarding_ctrl.sv
// hazard_forwarding_ctrl: EX-stage bypass selects, load-use stall FSM and stall-cycle counter
module hazard_forwarding_ctrl
   import pipe_pkg::*;
#(
   parameter int REG_AW   = 5,
   parameter int NUM_SRC  = 2,
   parameter int LOAD_LAT = 1,
   parameter int CNT_W    = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_SRC*REG_AW-1:0] ifid_rs,
   input  logic [NUM_SRC-1:0]        ifid_rs_used,
   input  logic [NUM_SRC*REG_AW-1:0] idex_rs,
   input  logic [NUM_SRC-1:0]        idex_rs_used,
   input  logic [REG_AW-1:0]         idex_rd,
   input  logic                      idex_wb,
   input  logic                      idex_mem_read,
   input  logic [REG_AW-1:0]         exmem_rd,
   input  logic                      exmem_wb,
   input  logic [REG_AW-1:0]         memwb_rd,
   input  logic                      memwb_wb,
   input  logic                      flush,
   input  logic                      clr_stats,
   output logic [2*NUM_SRC-1:0]      fwd_sel,
   output logic                      pc_hold,
   output logic                      ifid_hold,
   output logic                      idex_bubble,
   output logic [CNT_W-1:0]          stall_count
);
   localparam int REM_W = $clog2(LOAD_LAT + 1);

   if (LOAD_LAT < 1 || LOAD_LAT > 8) begin : g_bad_load_lat
      $error("hazard_forwarding_ctrl: LOAD_LAT must be in 1..8");
   end

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
      fwd_select #(.REG_AW(REG_AW)) u_fwd_select (
         .rs       (idex_rs[i*REG_AW +: REG_AW]),
         .used     (idex_rs_used[i]),
         .exmem_rd (exmem_rd),
         .exmem_wb (exmem_wb),
         .memwb_rd (memwb_rd),
         .memwb_wb (memwb_wb),
         .sel      (fwd_sel[2*i +: 2])
      );
   end

   state_t           state_q, state_d;
   logic [REM_W-1:0] rem_q, rem_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             src_match;
   logic             haz;
   logic             stall;

   // load-use hazard: a load in ID/EX whose destination feeds an IF/ID operand
   always_comb begin
      src_match = 1'b0;
      for (int i = 0; i < NUM_SRC; i++)
         src_match = src_match | (ifid_rs_used[i] && (ifid_rs[i*REG_AW +: REG_AW] == idex_rd));
      haz = idex_mem_read && idex_wb && (idex_rd != REG_AW'(REG_X0)) && src_match;
   end

   // stall sequencing: first stall cycle is the detection cycle, STALL covers the rest
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      stall   = (state_q == ST_IDLE) ? (haz && !flush) : !flush;
      if (flush) begin
         state_d = ST_IDLE;
         rem_d   = '0;
      end else if (state_q == ST_IDLE) begin
         if (haz && LOAD_LAT > 1) begin
            state_d = ST_STALL;
            rem_d   = REM_W'(LOAD_LAT - 1);
         end
      end else begin
         rem_d   = rem_q - REM_W'(1);
         state_d = (rem_q == REM_W'(1)) ? ST_IDLE : ST_STALL;
      end
      cnt_d = clr_stats ? '0 : (stall && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
   end

   // state, remaining-cycle and performance-counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         rem_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
      end
   end

   assign pc_hold     = stall && rst_n;
   assign ifid_hold   = stall && rst_n;
   assign idex_bubble = stall && rst_n;
   assign stall_count = cnt_q;
endmodule

// File: tb/tb_hazard_forwarding_ctrl.sv
// tb_hazard_forwarding_ctrl: directed checks of forwarding, load-use stalls, flush, reset and counter saturation
module tb_hazard_forwarding_ctrl;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [9:0]  ifid_rs;
   logic [1:0]  ifid_rs_used;
   logic [9:0]  idex_rs;
   logic [1:0]  idex_rs_used;
   logic [4:0]  idex_rd;
   logic        idex_wb;
   logic        idex_mem_read;
   logic [4:0]  exmem_rd;
   logic        exmem_wb;
   logic [4:0]  memwb_rd;
   logic        memwb_wb;
   logic        flush;
   logic        clr_stats;

   logic [3:0]  fwd_a, fwd_b, fwd_c;
   logic        pch_a, pch_b, pch_c;
   logic        ifh_a, ifh_b, ifh_c;
   logic        bub_a, bub_b, bub_c;
   logic [15:0] cnt_a, cnt_b;
   logic [3:0]  cnt_c;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   hazard_forwarding_ctrl #(.LOAD_LAT(1)) u_lat1 (
      .clk(clk), .rst_n(rst_n), .ifid_rs(ifid_rs), .ifid_rs_used(ifid_rs_used),
      .idex_rs(idex_rs), .idex_rs_used(idex_rs_used), .idex_rd(idex_rd), .idex_wb(idex_wb),
      .idex_mem_read(idex_mem_read), .exmem_rd(exmem_rd), .exmem_wb(exmem_wb),
      .memwb_rd(memwb_rd), .memwb_wb(memwb_wb), .flush(flush), .clr_stats(clr_stats),
      .fwd_sel(fwd_a), .pc_hold(pch_a), .ifid_hold(ifh_a), .idex_bubble(bub_a), .stall_count(cnt_a));

   hazard_forwarding_ctrl #(.LOAD_LAT(3)) u_lat3 (
      .clk(clk), .rst_n(rst_n), .ifid_rs(ifid_rs), .ifid_rs_used(ifid_rs_used),
      .idex_rs(idex_rs), .idex_rs_used(idex_rs_used), .idex_rd(idex_rd), .idex_wb(idex_wb),
      .idex_mem_read(idex_mem_read), .exmem_rd(exmem_rd), .exmem_wb(exmem_wb),
      .memwb_rd(memwb_rd), .memwb_wb(memwb_wb), .flush(flush), .clr_stats(clr_stats),
      .fwd_sel(fwd_b), .pc_hold(pch_b), .ifid_hold(ifh_b), .idex_bubble(bub_b), .stall_count(cnt_b));

   hazard_forwarding_ctrl #(.LOAD_LAT(1), .CNT_W(4)) u_cnt4 (
      .clk(clk), .rst_n(rst_n), .ifid_rs(ifid_rs), .ifid_rs_used(ifid_rs_used),
      .idex_rs(idex_rs), .idex_rs_used(idex_rs_used), .idex_rd(idex_rd), .idex_wb(idex_wb),
      .idex_mem_read(idex_mem_read), .exmem_rd(exmem_rd), .exmem_wb(exmem_wb),
      .memwb_rd(memwb_rd), .memwb_wb(memwb_wb), .flush(flush), .clr_stats(clr_stats),
      .fwd_sel(fwd_c), .pc_hold(pch_c), .ifid_hold(ifh_c), .idex_bubble(bub_c), .stall_count(cnt_c));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_haz(input logic on);
      idex_mem_read = on;
      idex_wb       = on;
      idex_rd       = 5'd3;
      ifid_rs       = {5'd3, 5'd9};
      ifid_rs_used  = 2'b10;
   endtask

   task automatic clear_stats();
      clr_stats = 1'b1;
      tick();
      clr_stats = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      set_haz(1'b1);
      #2;
      tests++;
      if ({pch_a, ifh_a, bub_a, pch_b, ifh_b, bub_b} !== 6'b0) begin
         fails++;
         $display("FAIL reset_outputs: got %b required 000000", {pch_a, ifh_a, bub_a, pch_b, ifh_b, bub_b});
      end
      tick();
      tests++;
      if (cnt_a !== 16'd0 || cnt_b !== 16'd0 || cnt_c !== 4'd0) begin
         fails++;
         $display("FAIL reset_count: got %0d/%0d/%0d required 0/0/0", cnt_a, cnt_b, cnt_c);
      end
      set_haz(1'b0);
      rst_n = 1'b1;
      #3;
      tests++;
      if (pch_b !== 1'b0) begin
         fails++;
         $display("FAIL reset_idle: got %b required 0", pch_b);
      end
   endtask

   task automatic test_forwarding();
      idex_rs = {5'd5, 5'd5}; idex_rs_used = 2'b11;
      exmem_rd = 5'd5; exmem_wb = 1'b1; memwb_rd = 5'd5; memwb_wb = 1'b1;
      #1;
      tests++;
      if (fwd_a !== 4'b1010) begin
         fails++;
         $display("FAIL fwd_both: got %b required 1010", fwd_a);
      end
      exmem_wb = 1'b0;
      #1;
      tests++;
      if (fwd_a !== 4'b0101) begin
         fails++;
         $display("FAIL fwd_memwb: got %b required 0101", fwd_a);
      end
      idex_rs = {5'd5, 5'd0}; exmem_rd = 5'd0; exmem_wb = 1'b1; memwb_wb = 1'b0;
      #1;
      tests++;
      if (fwd_a[1:0] !== 2'b00) begin
         fails++;
         $display("FAIL fwd_x0: got %b required 00", fwd_a[1:0]);
      end
      idex_rs = {5'd5, 5'd7}; idex_rs_used = 2'b10; exmem_rd = 5'd7;
      memwb_rd = 5'd5; memwb_wb = 1'b1;
      #1;
      tests++;
      if (fwd_a !== 4'b0100) begin
         fails++;
         $display("FAIL fwd_unused: got %b required 0100", fwd_a);
      end
      exmem_wb = 1'b0; memwb_wb = 1'b0;
   endtask

   task automatic test_load_lat();
      set_haz(1'b1);
      #3;
      tests++;
      if ({pch_a, ifh_a, bub_a, pch_b, ifh_b, bub_b} !== 6'b111111) begin
         fails++;
         $display("FAIL stall_detect: got %b required 111111", {pch_a, ifh_a, bub_a, pch_b, ifh_b, bub_b});
      end
      tick();
      set_haz(1'b0);
      #3;
      tests++;
      if ({pch_a, pch_b} !== 2'b01) begin
         fails++;
         $display("FAIL stall_cycle2: got %b required 01", {pch_a, pch_b});
      end
      tick();
      #3;
      tests++;
      if ({pch_a, pch_b} !== 2'b01) begin
         fails++;
         $display("FAIL stall_cycle3: got %b required 01", {pch_a, pch_b});
      end
      tick();
      #3;
      tests++;
      if ({pch_a, pch_b} !== 2'b00) begin
         fails++;
         $display("FAIL stall_end: got %b required 00", {pch_a, pch_b});
      end
      tests++;
      if (cnt_a !== 16'd1 || cnt_b !== 16'd3 || cnt_c !== 4'd1) begin
         fails++;
         $display("FAIL stall_count_lat: got %0d/%0d/%0d required 1/3/1", cnt_a, cnt_b, cnt_c);
      end
   endtask

   task automatic test_flush();
      clear_stats();
      set_haz(1'b1);
      #3;
      tests++;
      if (pch_b !== 1'b1) begin
         fails++;
         $display("FAIL flush_pre: got %b required 1", pch_b);
      end
      tick();
      set_haz(1'b0);
      flush = 1'b1;
      #1;
      tests++;
      if (pch_b !== 1'b0) begin
         fails++;
         $display("FAIL flush_cycle: got %b required 0", pch_b);
      end
      tick();
      flush = 1'b0;
      #3;
      tests++;
      if (pch_b !== 1'b0 || cnt_b !== 16'd1) begin
         fails++;
         $display("FAIL flush_after: got stall %b count %0d required stall 0 count 1", pch_b, cnt_b);
      end
      set_haz(1'b1);
      flush = 1'b1;
      #1;
      tests++;
      if (pch_a !== 1'b0 || pch_b !== 1'b0) begin
         fails++;
         $display("FAIL flush_haz: got %b%b required 00", pch_a, pch_b);
      end
      tick();
      set_haz(1'b0);
      flush = 1'b0;
      #3;
      tests++;
      if (pch_b !== 1'b0 || cnt_b !== 16'd1) begin
         fails++;
         $display("FAIL flush_discard: got stall %b count %0d required stall 0 count 1", pch_b, cnt_b);
      end
   endtask

   task automatic test_async_reset();
      set_haz(1'b1);
      tick();
      set_haz(1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      tests++;
      if (pch_b !== 1'b0 || cnt_b !== 16'd0) begin
         fails++;
         $display("FAIL async_reset: got stall %b count %0d required stall 0 count 0", pch_b, cnt_b);
      end
      #1;
      rst_n = 1'b1;
      tick();
      #3;
      tests++;
      if (pch_b !== 1'b0) begin
         fails++;
         $display("FAIL post_reset1: got %b required 0", pch_b);
      end
      tick();
      #3;
      tests++;
      if (pch_b !== 1'b0 || cnt_b !== 16'd0) begin
         fails++;
         $display("FAIL post_reset2: got stall %b count %0d required stall 0 count 0", pch_b, cnt_b);
      end
   endtask

   task automatic test_saturate();
      clear_stats();
      set_haz(1'b1);
      for (int k = 0; k < 20; k++) tick();
      #2;
      tests++;
      if (cnt_c !== 4'd15) begin
         fails++;
         $display("FAIL count_saturate: got %0d required 15", cnt_c);
      end
      tests++;
      if (cnt_a !== 16'd20) begin
         fails++;
         $display("FAIL count_wide: got %0d required 20", cnt_a);
      end
      clr_stats = 1'b1;
      tick();
      clr_stats = 1'b0;
      #2;
      tests++;
      if (cnt_c !== 4'd0 || cnt_a !== 16'd0 || pch_c !== 1'b1) begin
         fails++;
         $display("FAIL clr_priority: got %0d/%0d stall %b required 0/0 stall 1", cnt_c, cnt_a, pch_c);
      end
      set_haz(1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      ifid_rs = '0; ifid_rs_used = '0; idex_rs = '0; idex_rs_used = '0;
      idex_rd = '0; idex_wb = 1'b0; idex_mem_read = 1'b0;
      exmem_rd = '0; exmem_wb = 1'b0; memwb_rd = '0; memwb_wb = 1'b0;
      flush = 1'b0; clr_stats = 1'b0;
      test_reset();
      test_forwarding();
      tick();
      test_load_lat();
      tick();
      test_flush();
      tick();
      test_async_reset();
      tick();
      test_saturate();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/hazard_forwarding_ctrl.md
Name: hazard_forwarding_ctrl

Overview:
Parametrised forwarding and load-use hazard controller for the five-stage pipeline. It generates per-operand bypass selects for the EX stage with a fixed priority: EX/MEM first, then MEM/WB, then the register file. It detects load-use hazards between ID/EX and IF/ID and holds the front end for a configurable number of cycles to suit multi-cycle data memory. It also keeps a saturating stall-cycle counter for performance measurement.

Parameters:
- REG_AW, 5: register-address width.
- NUM_SRC, 2: source operands per instruction.
- LOAD_LAT, 1: stall cycles per load-use hazard. Legal range 1..8.
- CNT_W, 16: stall-counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- ifid_rs  in  NUM_SRC*REG_AW  IF/ID source addresses. Operand i is at [i*REG_AW +: REG_AW].
- ifid_rs_used  in  NUM_SRC  IF/ID operand-valid bits.
- idex_rs  in  NUM_SRC*REG_AW  ID/EX source addresses.
- idex_rs_used  in  NUM_SRC  ID/EX operand-valid bits.
- idex_rd  in  REG_AW  ID/EX destination.
- idex_wb  in  1  ID/EX writes back.
- idex_mem_read  in  1  ID/EX is a load.
- exmem_rd  in  REG_AW  EX/MEM destination.
- exmem_wb  in  1  EX/MEM writes back.
- memwb_rd  in  REG_AW  MEM/WB destination.
- memwb_wb  in  1  MEM/WB writes back.
- flush  in  1  redirect (taken branch or jump) this cycle.
- clr_stats  in  1  synchronous clear of stall_count.
- fwd_sel  out  2*NUM_SRC  per-operand select. Operand i is at [2*i +: 2]. 00 = regfile, 10 = EX/MEM, 01 = MEM/WB.
- pc_hold  out  1  freeze PC.
- ifid_hold  out  1  freeze IF/ID.
- idex_bubble  out  1  insert NOP into ID/EX.
- stall_count  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Reset (rst_n low, asynchronous):
  - FSM goes to IDLE; the remaining-cycle counter clears; stall_count = 0.
  - pc_hold, ifid_hold and idex_bubble are forced 0 while reset is asserted.
  - fwd_sel is combinational and is not forced by reset.
- Forwarding (combinational, fully assigned every evaluation, no latches), per operand i:
  - 10 if exmem_wb, exmem_rd != 0, exmem_rd == idex_rs[i] and idex_rs_used[i].
  - Else 01 under the same conditions on memwb_wb / memwb_rd.
  - Else 00.
  - Register x0 is never forwarded. EX/MEM always wins when both stages match.
- Hazard term (combinational):
  - haz = idex_mem_read & idex_wb & (idex_rd != 0) & OR over i of (ifid_rs_used[i] & ifid_rs[i] == idex_rd).
- FSM states: IDLE and STALL. A remaining-cycle counter rem holds clog2(LOAD_LAT+1) bits.
- IDLE:
  - stall = haz & ~flush.
  - If stall and LOAD_LAT > 1: at the next edge go to STALL with rem = LOAD_LAT-1.
  - Otherwise stay in IDLE.
- STALL:
  - stall = ~flush.
  - Each edge decrements rem. Transition to IDLE on the edge where rem == 1.
  - haz is ignored while in STALL, because the load has already left ID/EX.
- Outputs: pc_hold = ifid_hold = idex_bubble = stall.
- Total stall per hazard is exactly LOAD_LAT consecutive cycles, with the first cycle being the detection cycle (zero latency). With LOAD_LAT = 1 the FSM never leaves IDLE.
- flush in any state:
  - Stall outputs are 0 that cycle.
  - Next state is IDLE and rem clears.
  - A hazard coincident with flush is discarded.
- stall_count:
  - Increments at each edge where stall = 1.
  - Saturates at all-ones.
  - clr_stats takes priority over an increment in the same cycle (result 0).
- Parameter check: LOAD_LAT outside 1..8 fails elaboration through a generate-time error.

Decomposition:
- Shared package pipe_pkg holds:
  - localparams FWD_RF = 2'b00, FWD_MEMWB = 2'b01, FWD_EXMEM = 2'b10;
  - the state encodings ST_IDLE and ST_STALL;
  - REG_X0 = 0.
- One natural sub-module, fwd_select: the combinational single-operand priority comparator. It is instantiated NUM_SRC times in a generate loop. The FSM and stall counter stay in the top module.

Test Plan:
- Both stages write; exmem_rd = memwb_rd = 5 = idex_rs[0] = idex_rs[1], both used -> fwd_sel = 4'b1010. Drop exmem_wb -> fwd_sel = 4'b0101.
- Register x0: exmem_rd = 0 = idex_rs[0], exmem_wb = 1 -> fwd_sel[1:0] = 00. Set idex_rs_used[0] = 0 with rd 7 = rs 7 -> 00.
- LOAD_LAT = 1: load with idex_rd = 3, ifid_rs[1] = 3 used -> stall high for exactly 1 cycle, stall_count = 1. Repeat with LOAD_LAT = 3 -> stall high for 3 consecutive cycles, stall_count = 3.
- LOAD_LAT = 3, flush asserted in the 2nd stall cycle -> stall = 0 that cycle and after, FSM in IDLE, stall_count = 1.
- rst_n pulsed low mid-STALL (asynchronous, between edges) -> outputs drop to 0 immediately, stall_count = 0. After release with no hazard, stall stays 0.
- CNT_W = 4: force 20 stall cycles -> stall_count = 15. clr_stats coincident with a stall cycle -> stall_count = 0.
